// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family. Address widths depend on module
// parameters, so each module derives them from clog2 locally.
package fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_nto1_if.sv
// Bus bundle for the N-to-1 width-down FIFO: wide write side, narrow read side.
interface fifo_nto1_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NSIZE = 4,
    parameter int DEPTH = 4
);
    localparam int WAW = clog2(DEPTH);
    localparam int RAW = clog2(DEPTH * NSIZE);

    // Handshake: a write transfers on an edge where wr_en && !wr_full; a read
    // transfers where rd_en && !rd_empty, and its item appears on rd_data with
    // rd_vld=1 after that edge. Requests against full/empty are dropped.
    logic                     wr_en;
    logic [DSIZE*NSIZE-1:0]   wr_data;
    logic                     wr_full;
    logic                     wr_almost_full;
    logic [WAW:0]             wr_count;
    logic                     rd_en;
    logic [DSIZE-1:0]         rd_data;
    logic                     rd_vld;
    logic                     rd_last;
    logic                     rd_empty;
    logic                     rd_almost_empty;
    logic [RAW:0]             rd_count;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, wr_almost_full, wr_count,
        input  rd_data, rd_vld, rd_last, rd_empty, rd_almost_empty, rd_count
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, wr_almost_full, wr_count,
        output rd_data, rd_vld, rd_last, rd_empty, rd_almost_empty, rd_count
    );
endinterface

// File: rtl/fifo_nto1_mem.sv
// Wide-word storage with one write port and a combinational narrow slice read.
// Slice 0 is the most significant item of the stored word.
module fifo_nto1_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NSIZE = 4,
    parameter int DEPTH = 4,
    localparam int WAW   = clog2(DEPTH),
    localparam int SFBIT = clog2(NSIZE),
    localparam int SW    = (SFBIT == 0) ? 1 : SFBIT
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [WAW-1:0]         wr_addr,
    input  logic [DSIZE*NSIZE-1:0] wr_data,
    input  logic [WAW-1:0]         rd_word,
    input  logic [SW-1:0]          rd_slice,
    output logic [DSIZE-1:0]       rd_item
);
    logic [DSIZE*NSIZE-1:0]       mem [DEPTH];
    logic [NSIZE-1:0][DSIZE-1:0]  word;
    logic [SW-1:0]                sel;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Packed element k holds bits [k*DSIZE +: DSIZE], so slice s is element NSIZE-1-s.
    always_comb begin
        word    = mem[rd_word];
        sel     = SW'(NSIZE - 1) - rd_slice;
        rd_item = word[sel];
    end
endmodule

// File: rtl/fifo_nto1.sv
// Single-clock width-down FIFO: one wide word in, NSIZE narrow items out, MSB first.
// Pointers, occupancy counters, flag decode and the registered read output live here.
module fifo_nto1
    import fifo_pkg::*;
#(
    parameter int               DSIZE     = 8,
    parameter int               NSIZE     = 4,
    parameter int               DEPTH     = 4,
    parameter int               ALMOST    = 2,
    parameter logic [DSIZE-1:0] DEF_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
    fifo_nto1_if.slave  bus
);
    localparam int WAW   = clog2(DEPTH);
    localparam int RAW   = clog2(DEPTH * NSIZE);
    localparam int SFBIT = clog2(NSIZE);
    localparam int SW    = (SFBIT == 0) ? 1 : SFBIT;

    logic [WAW-1:0] wr_ptr;
    logic [RAW-1:0] rd_ptr;
    logic [WAW:0]   wcnt, wcnt_nxt;
    logic [RAW:0]   rcnt, rcnt_nxt;
    logic           full, empty;
    logic           wr_acc, rd_acc;
    logic [WAW-1:0] rd_word;
    logic [SW-1:0]  rd_slice;
    logic           slice_last;
    logic [DSIZE-1:0] rd_item;

    assign full   = (wcnt == (WAW+1)'(DEPTH));
    assign empty  = (rcnt == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    // Upper read-pointer bits pick the word, the low SFBIT bits pick the slice.
    assign rd_word = rd_ptr[RAW-1 -: WAW];
    if (SFBIT == 0) begin : g_single
        assign rd_slice = '0;
    end else begin : g_multi
        assign rd_slice = rd_ptr[SFBIT-1:0];
    end
    assign slice_last = (rd_slice == SW'(NSIZE - 1));

    fifo_nto1_mem #(
        .DSIZE (DSIZE),
        .NSIZE (NSIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .we       (wr_acc),
        .wr_addr  (wr_ptr),
        .wr_data  (bus.wr_data),
        .rd_word  (rd_word),
        .rd_slice (rd_slice),
        .rd_item  (rd_item)
    );

    // A wide slot is freed only when its final slice is consumed.
    always_comb begin
        wcnt_nxt = wcnt;
        rcnt_nxt = rcnt;
        if (wr_acc) begin
            wcnt_nxt = wcnt_nxt + (WAW+1)'(1);
            rcnt_nxt = rcnt_nxt + (RAW+1)'(NSIZE);
        end
        if (rd_acc) begin
            rcnt_nxt = rcnt_nxt - (RAW+1)'(1);
            if (slice_last) begin
                wcnt_nxt = wcnt_nxt - (WAW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + WAW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + RAW'(1);
            wcnt <= wcnt_nxt;
            rcnt <= rcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= DEF_VALUE;
            bus.rd_vld  <= 1'b0;
            bus.rd_last <= 1'b0;
        end else begin
            bus.rd_vld  <= rd_acc;
            bus.rd_last <= rd_acc && slice_last;
            if (rd_acc) begin
                bus.rd_data <= rd_item;
            end
        end
    end

    assign bus.wr_full         = full;
    assign bus.rd_empty        = empty;
    assign bus.wr_count        = wcnt;
    assign bus.rd_count        = rcnt;
    assign bus.wr_almost_full  = (wcnt >= (WAW+1)'(DEPTH - ALMOST));
    assign bus.rd_almost_empty = (rcnt <= (RAW+1)'(ALMOST));

    a_wcnt_range: assert property (@(posedge clk) disable iff (rst) wcnt <= (WAW+1)'(DEPTH));
    a_rcnt_range: assert property (@(posedge clk) disable iff (rst) rcnt <= (RAW+1)'(DEPTH * NSIZE));
endmodule

// File: tb/tb_fifo_nto1.sv
// Directed bench for fifo_nto1 (DSIZE=8, NSIZE=4, DEPTH=4, ALMOST=2):
// a vector table for reset, single word, full/drop, no-bypass and mid-word reset, plus a streaming run.
module tb_fifo_nto1;
  localparam int DSIZE  = 8;
  localparam int NSIZE  = 4;
  localparam int DEPTH  = 4;
  localparam int ALMOST = 2;
  localparam int W      = 9;

  logic clk;
  logic rst;

  fifo_nto1_if #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH)) bus ();

  fifo_nto1 #(
    .DSIZE     (DSIZE),
    .NSIZE     (NSIZE),
    .DEPTH     (DEPTH),
    .ALMOST    (ALMOST),
    .DEF_VALUE (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  e_data;
    logic        e_vld;
    logic        e_last;
    logic        e_empty;
    logic        e_ae;
    logic        e_full;
    logic        e_af;
    int          e_rcnt;
    int          e_wcnt;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void add(input logic r, input logic we, input logic [31:0] wd, input logic re,
                              input logic [7:0] d, input logic v, input logic l, input logic em,
                              input logic ae, input logic fu, input logic af, input int rc, input int wc);
    vecs.push_back('{r, we, wd, re, d, v, l, em, ae, fu, af, rc, wc});
  endfunction

  task automatic drive(input logic r, input logic we, input logic [31:0] wd, input logic re);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
  endtask

  initial begin
    int cyc;
    int got;
    int wr_words;
    logic [W-1:0] e;
    logic [31:0] wd;

    drive(1'b1, 1'b1, 32'h0, 1'b1);

    //   rst we data          re   data  v  l  em ae fu af rc wc
    // reset with requests asserted
    add(1, 1, 32'hFFFFFFFF, 1, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 32'hFFFFFFFF, 1, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0);
    // single word, MSB first
    add(0, 1, 32'hA1B2C3D4, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 32'h0,        1, 8'hA1, 1, 0, 0, 0, 0, 0, 3, 1);
    add(0, 0, 32'h0,        1, 8'hB2, 1, 0, 0, 1, 0, 0, 2, 1);
    add(0, 0, 32'h0,        1, 8'hC3, 1, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 32'h0,        1, 8'hD4, 1, 1, 1, 1, 0, 0, 0, 0);
    // fill, drop while full, slot freed only on last slice
    add(0, 1, 32'h10111213, 0, 8'hD4, 0, 0, 0, 0, 0, 0, 4, 1);
    add(0, 1, 32'h20212223, 0, 8'hD4, 0, 0, 0, 0, 0, 1, 8, 2);
    add(0, 1, 32'h30313233, 0, 8'hD4, 0, 0, 0, 0, 0, 1, 12, 3);
    add(0, 1, 32'h40414243, 0, 8'hD4, 0, 0, 0, 0, 1, 1, 16, 4);
    add(0, 1, 32'hDEADBEEF, 0, 8'hD4, 0, 0, 0, 0, 1, 1, 16, 4);
    add(0, 0, 32'h0,        1, 8'h10, 1, 0, 0, 0, 1, 1, 15, 4);
    add(0, 0, 32'h0,        1, 8'h11, 1, 0, 0, 0, 1, 1, 14, 4);
    add(0, 0, 32'h0,        1, 8'h12, 1, 0, 0, 0, 1, 1, 13, 4);
    add(0, 1, 32'hDEADBEEF, 1, 8'h13, 1, 1, 0, 0, 0, 1, 12, 3);
    add(1, 0, 32'h0,        0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0);
    // read on empty with a simultaneous write: no bypass
    add(0, 1, 32'h11223344, 1, 8'h00, 0, 0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 32'h0,        1, 8'h11, 1, 0, 0, 0, 0, 0, 3, 1);
    add(0, 0, 32'h0,        1, 8'h22, 1, 0, 0, 1, 0, 0, 2, 1);
    add(0, 0, 32'h0,        1, 8'h33, 1, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 32'h0,        1, 8'h44, 1, 1, 1, 1, 0, 0, 0, 0);
    // reset mid-word
    add(0, 1, 32'h55667788, 0, 8'h44, 0, 0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 32'h0,        1, 8'h55, 1, 0, 0, 0, 0, 0, 3, 1);
    add(0, 0, 32'h0,        1, 8'h66, 1, 0, 0, 1, 0, 0, 2, 1);
    add(1, 1, 32'h01020304, 1, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 32'h99AABBCC, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 32'h0,        1, 8'h99, 1, 0, 0, 0, 0, 0, 3, 1);
    add(1, 0, 32'h0,        0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0);

    // The write at the first full cycle and the write alongside the freeing
    // read above both hit a full FIFO and must be dropped.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d rd_vld", i), 32'(bus.rd_vld), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d rd_last", i), 32'(bus.rd_last), 32'(vecs[i].e_last));
      chk($sformatf("v%0d rd_empty", i), 32'(bus.rd_empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d rd_almost_empty", i), 32'(bus.rd_almost_empty), 32'(vecs[i].e_ae));
      chk($sformatf("v%0d wr_full", i), 32'(bus.wr_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d wr_almost_full", i), 32'(bus.wr_almost_full), 32'(vecs[i].e_af));
      chk($sformatf("v%0d rd_count", i), 32'(bus.rd_count), vecs[i].e_rcnt);
      chk($sformatf("v%0d wr_count", i), 32'(bus.wr_count), vecs[i].e_wcnt);
    end

    // Streaming across several pointer wraps with a random read pattern.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc = 0;
    got = 0;
    wr_words = 0;
    while ((wr_words < 16 || exp_q.size() > 0) && cyc < 2000) begin
      bus.wr_en = (wr_words < 16) && !bus.wr_full;
      if (bus.wr_en) begin
        for (int j = 0; j < 4; j++) begin
          wd[31 - 8*j -: 8] = 8'(4*wr_words + j);
          exp_q.push_back({(j == 3), 8'(4*wr_words + j)});
        end
        bus.wr_data = wd;
        wr_words++;
      end
      bus.rd_en = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rd_vld) begin
        if (exp_q.size() == 0) begin
          chk("stream spurious rd_vld", 32'(bus.rd_vld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream rd_data", 32'(bus.rd_data), 32'(e[7:0]));
          chk("stream rd_last", 32'(bus.rd_last), 32'(e[8]));
          got++;
        end
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stream within budget", 32'(cyc < 2000), 32'd1);
    chk("stream item count", got, 64);
    @(posedge clk);
    #1;
    chk("stream end rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("stream end wr_count", 32'(bus.wr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
